result_sink: RTL and testbench

RESULT_SINK -- requirements
Module: result_sink

---
 rtl/result_sink.sv | 159 +++++++++++++++
 tb/tb_result_sink.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_sink.sv
// result_sink: captures the cpu result once per halt and serialises it as a
// byte stream. The frame is a header byte {3'b000, empty, trap}, followed by
// the eight result bytes when the captured stack was not empty.
// Byte order is set by LITTLE_ENDIAN.
// All outputs come straight from registers.
module result_sink #(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] result,
  input  logic        result_empty,
  input  logic [3:0]  trap,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [63:0] result_q;
  logic        empty_q;
  logic [3:0]  trap_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic        hs_s;
  logic [2:0]  idx_d;
  logic [7:0]  first_byte_d;
  logic [7:0]  next_byte_d;

  // Byte at stream position idx of a 64-bit word, honouring the byte order.
  function automatic logic [7:0] pick_byte(input logic [63:0] word,
                                           input logic [2:0]  idx);
    logic [2:0] pos;
    if (LITTLE_ENDIAN) begin
      pos = idx;
    end else begin
      pos = 3'd7 - idx;
    end
    pick_byte = word[{pos, 3'b000} +: 8];
  endfunction

  // Handshake detection and the byte to present after the next handshake.
  always_comb begin
    hs_s         = valid_q & out_ready;
    idx_d        = idx_q + 3'd1;
    first_byte_d = pick_byte(result_q, 3'd0);
    next_byte_d  = pick_byte(result_q, idx_d);
  end

  // Frame FSM: capture on halt, header, data bytes, then hold done until re-arm.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      result_q <= 64'd0;
      empty_q  <= 1'b0;
      trap_q   <= 4'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trap != 4'd0) begin
            // Snapshot everything now; later input changes do not reach the frame.
            trap_q   <= trap;
            result_q <= result;
            empty_q  <= result_empty;
            idx_q    <= 3'd0;
            data_q   <= {3'b000, result_empty, trap};
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= ST_HDR;
          end else begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (hs_s) begin
            if (empty_q) begin
              data_q  <= 8'd0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= 3'd0;
              data_q  <= first_byte_d;
              state_q <= ST_DATA;
            end
          end else begin
            // Stall: header byte and valid stay put.
            state_q <= ST_HDR;
          end
        end
        ST_DATA: begin
          if (hs_s) begin
            if (idx_q == 3'd7) begin
              idx_q   <= 3'd0;
              data_q  <= 8'd0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q  <= idx_d;
              data_q <= next_byte_d;
            end
          end else begin
            // Stall: current data byte and valid stay put.
            state_q <= ST_DATA;
          end
        end
        ST_DONE: begin
          if (trap == 4'd0) begin
            // cpu left the halted state: re-arm for the next halt.
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= 3'd0;
          data_q  <= 8'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_result_sink.sv
// Self-checking bench for result_sink: one little-endian and one big-endian
// instance share all inputs. Expected frames come from a byte-list model and
// are queued per instance; a monitor pops them on every handshake.
module tb_result_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] result = 64'd0;
  logic        result_empty = 1'b0;
  logic [3:0]  trap = 4'd0;
  logic        out_ready = 1'b0;

  logic [7:0]  le_data, be_data;
  logic        le_valid, be_valid, le_busy, be_busy, le_done, be_done;

  int          n_pass = 0;
  int          n_total = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random

  logic [7:0]  q_le[$];
  logic [7:0]  q_be[$];

  always #5 clk = ~clk;

  result_sink #(.LITTLE_ENDIAN(1'b1)) u_le (
    .clk(clk), .reset(reset), .result(result), .result_empty(result_empty),
    .trap(trap), .out_data(le_data), .out_valid(le_valid), .out_ready(out_ready),
    .busy(le_busy), .done(le_done)
  );

  result_sink #(.LITTLE_ENDIAN(1'b0)) u_be (
    .clk(clk), .reset(reset), .result(result), .result_empty(result_empty),
    .trap(trap), .out_data(be_data), .out_valid(be_valid), .out_ready(out_ready),
    .busy(be_busy), .done(be_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the frame is a header and, unless empty, 8 bytes in stream order.
  function automatic void push_frame(input logic [3:0] t, input logic [63:0] r, input logic e);
    q_le.push_back({3'b000, e, t});
    q_be.push_back({3'b000, e, t});
    if (!e) begin
      for (int i = 0; i < 8; i++) begin
        q_le.push_back(8'((r >> (8 * i)) & 64'hFF));
        q_be.push_back(8'((r >> (8 * (7 - i))) & 64'hFF));
      end
    end
  endfunction

  // Ready driver: changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares presented bytes with the queue head and pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      check("busy_le", le_busy, le_valid);
      check("busy_be", be_busy, be_valid);
      check("done_with_valid_le", le_done & le_valid, 1'b0);
      check("done_with_valid_be", be_done & be_valid, 1'b0);
      if (le_valid) begin
        if (q_le.size() == 0) check("le_unexpected_byte", 64'(q_le.size()), 64'd1);
        else begin
          check("le_byte", le_data, q_le[0]);
          if (out_ready) void'(q_le.pop_front());
        end
      end
      if (be_valid) begin
        if (q_be.size() == 0) check("be_unexpected_byte", 64'(q_be.size()), 64'd1);
        else begin
          check("be_byte", be_data, q_be[0]);
          if (out_ready) void'(q_be.pop_front());
        end
      end
    end
  end

  task automatic start_frame(input logic [3:0] t, input logic [63:0] r, input logic e);
    @(negedge clk);
    trap = t;
    result = r;
    result_empty = e;
    push_frame(t, r, e);
    @(negedge clk);
    check("latency_le", le_valid, 1'b1);
    check("latency_be", be_valid, 1'b1);
  endtask

  // Wait for done (bounded); exp_cycles counts negedges from the capture edge, 0 = unchecked.
  task automatic wait_done(input int exp_cycles);
    int n;
    n = 1;
    while (!(le_done && be_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(n < 400), 64'd1);
    if (exp_cycles != 0) check("frame_cycles", 64'(n), 64'(exp_cycles));
    check("done_le", le_done, 1'b1);
    check("done_be", be_done, 1'b1);
    check("idle_valid_le", le_valid, 1'b0);
    check("queue_le_drained", 64'(q_le.size()), 64'd0);
    check("queue_be_drained", 64'(q_be.size()), 64'd0);
    if (trap != 4'd0) begin
      @(negedge clk);
      check("done_hold_le", le_done, 1'b1);
      check("done_hold_be", be_done, 1'b1);
    end
  endtask

  task automatic rearm();
    @(negedge clk);
    trap = 4'd0;
    @(negedge clk);
    check("rearm_done_le", le_done, 1'b0);
    check("rearm_done_be", be_done, 1'b0);
    check("rearm_valid_le", le_valid, 1'b0);
  endtask

  initial begin
    logic [3:0]  t;
    logic [63:0] r;
    logic        e;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_le", le_data, 8'h00);
    check("rst_data_be", be_data, 8'h00);
    check("rst_valid", le_valid | be_valid, 1'b0);
    check("rst_busy", le_busy | be_busy, 1'b0);
    check("rst_done", le_done | be_done, 1'b0);
    reset = 1'b0;

    // Value 1, trap 1, always ready: 9 bytes back to back.
    rdy_mode = 0;
    start_frame(4'h1, 64'h1, 1'b0);
    wait_done(10);
    rearm();

    // Empty stack: single header byte 8'h12.
    start_frame(4'h2, 64'hDEAD_BEEF_0000_1111, 1'b1);
    wait_done(2);
    rearm();

    // Toggling ready with a distinctive value (big-endian gives 01..08).
    rdy_mode = 1;
    start_frame(4'h5, 64'h0102030405060708, 1'b0);
    wait_done(0);
    rearm();

    // Inputs change after capture; frame keeps the captured values.
    rdy_mode = 2;
    start_frame(4'h7, 64'h8877665544332211, 1'b0);
    repeat (3) @(negedge clk);
    result = 64'hFFFF;
    result_empty = 1'b1;
    trap = 4'h9;
    wait_done(0);
    rearm();

    // trap drops mid-frame: frame still completes, then re-arms.
    rdy_mode = 0;
    start_frame(4'hA, 64'h1357_9BDF_2468_ACE0, 1'b0);
    @(negedge clk);
    trap = 4'h0;
    wait_done(0);
    rearm();

    // Reset after the third byte: outputs clear, then a full new frame.
    start_frame(4'h4, 64'hCAFE_F00D_1234_5678, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    q_le.delete();
    q_be.delete();
    @(negedge clk);
    check("mid_rst_valid", le_valid | be_valid, 1'b0);
    check("mid_rst_data", {le_data, be_data}, 16'h0000);
    check("mid_rst_busy", le_busy | be_busy, 1'b0);
    check("mid_rst_done", le_done | be_done, 1'b0);
    reset = 1'b0;
    push_frame(trap, result, result_empty);
    @(negedge clk);
    check("post_rst_latency", le_valid & be_valid, 1'b1);
    wait_done(0);
    rearm();

    // Second halt after re-arm: trap 3, value 2A.
    start_frame(4'h6, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
    wait_done(10);
    rearm();
    start_frame(4'h3, 64'h2A, 1'b0);
    wait_done(10);
    rearm();

    // Randomised frames.
    for (int k = 0; k < 20; k++) begin
      rdy_mode = $urandom_range(0, 2);
      t = 4'($urandom_range(1, 15));
      r = {$urandom, $urandom};
      e = ($urandom_range(0, 3) == 0);
      start_frame(t, r, e);
      wait_done((rdy_mode == 0) ? (e ? 2 : 10) : 0);
      rearm();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
